// File: rtl/pc_gen.sv
// Fetch-address generator: owns the F-stage PC and selects the next fetch address
// from sequential, branch, jump, exception and eret sources.
module pc_gen #(
    parameter int          ADDR_WIDTH  = 32,
    parameter logic [31:0] RESET_PC    = 32'h0000_3000,
    parameter logic [31:0] EXC_PC      = 32'h0000_4180,
    parameter logic [31:0] IMEM_BASE   = 32'h0000_3000,
    parameter logic [31:0] IMEM_SIZE   = 32'h0000_3000,
    parameter bit          DELAY_SLOT  = 1'b1,
    parameter int          COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic [ADDR_WIDTH-1:0]  D_PC,
    input  logic [25:0]            instr_index_offset,
    input  logic [ADDR_WIDTH-1:0]  register_value,
    input  logic [1:0]             branch,
    input  logic [1:0]             jump,
    input  logic                   cmp_result,
    input  logic                   exc_req,
    input  logic                   eret_req,
    input  logic [ADDR_WIDTH-1:0]  epc,
    input  logic                   cnt_clear,
    output logic [ADDR_WIDTH-1:0]  F_PC,
    output logic [ADDR_WIDTH-1:0]  next_PC,
    output logic                   flush_fd,
    output logic                   fetch_fault,
    output logic [COUNT_WIDTH-1:0] redirect_count
);

    localparam logic [ADDR_WIDTH-1:0] RESET_PC_W = RESET_PC[ADDR_WIDTH-1:0];
    localparam logic [ADDR_WIDTH-1:0] EXC_PC_W   = EXC_PC[ADDR_WIDTH-1:0];
    localparam logic [32:0]           WIN_LO     = {1'b0, IMEM_BASE};
    localparam logic [32:0]           WIN_HI     = {1'b0, IMEM_BASE} + {1'b0, IMEM_SIZE};

    logic [ADDR_WIDTH-1:0]  f_pc_q, f_pc_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  seq_target, br_target, idx_target, br_offset, d_target;
    logic                   jump_taken, branch_taken, taken_d, count_inc;
    logic [32:0]            pc_ext;

    // Targets are computed unconditionally; only the selection depends on control.
    assign br_offset  = {{(ADDR_WIDTH-18){instr_index_offset[15]}}, instr_index_offset[15:0], 2'b00};
    assign seq_target = f_pc_q + ADDR_WIDTH'(4);
    assign br_target  = D_PC + ADDR_WIDTH'(4) + br_offset;
    assign idx_target = {D_PC[ADDR_WIDTH-1:28], instr_index_offset, 2'b00};

    assign jump_taken   = (jump == 2'd1) || (jump == 2'd2);
    assign branch_taken = (branch == 2'd2) || ((branch == 2'd1) && cmp_result);
    assign taken_d      = jump_taken || branch_taken;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        d_target = br_target;
        if (jump == 2'd1) begin
            d_target = idx_target;
        end else if (jump == 2'd2) begin
            d_target = register_value;
        end

        f_pc_d = seq_target;
        if (exc_req) begin
            f_pc_d = EXC_PC_W;
        end else if (eret_req) begin
            f_pc_d = epc;
        end else if (taken_d) begin
            f_pc_d = d_target;
        end
    end

    assign count_inc = taken_d && !stall && !exc_req && !eret_req;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clear) begin
            cnt_d = '0;
        end else if (count_inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            f_pc_q <= RESET_PC_W;
            cnt_q  <= '0;
        end else begin
            if (exc_req || eret_req || !stall) begin
                f_pc_q <= f_pc_d;
            end
            cnt_q <= cnt_d;
        end
    end

    assign pc_ext      = 33'(f_pc_q);
    assign fetch_fault = (f_pc_q[1:0] != 2'b00) || (pc_ext < WIN_LO) || (pc_ext >= WIN_HI);

    // With a delay slot the F instruction is architecturally executed, so only exceptions flush.
    assign flush_fd = exc_req || eret_req || (!DELAY_SLOT && taken_d && !stall);

    assign F_PC           = f_pc_q;
    assign next_PC        = f_pc_d;
    assign redirect_count = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Randomised and directed bench for pc_gen against a behavioural next-PC model;
// three instances cover default, no-delay-slot and 2-bit counter configurations.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset, stall, cmp_result, exc_req, eret_req, cnt_clear;
    logic [31:0] D_PC, register_value, epc;
    logic [25:0] instr_index_offset;
    logic [1:0]  branch, jump;

    logic [31:0] f_pc_a, next_a, f_pc_b, next_b, f_pc_c, next_c;
    logic        flush_a, flush_b, flush_c, fault_a, fault_b, fault_c;
    logic [15:0] cnt_a, cnt_b;
    logic [1:0]  cnt_c;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_pc;
    int          m_cnt16, m_cnt2;

    always #5 clk = ~clk;

    pc_gen u_dut (
        .clk(clk), .reset(reset), .stall(stall), .D_PC(D_PC),
        .instr_index_offset(instr_index_offset), .register_value(register_value),
        .branch(branch), .jump(jump), .cmp_result(cmp_result), .exc_req(exc_req),
        .eret_req(eret_req), .epc(epc), .cnt_clear(cnt_clear),
        .F_PC(f_pc_a), .next_PC(next_a), .flush_fd(flush_a),
        .fetch_fault(fault_a), .redirect_count(cnt_a)
    );

    pc_gen #(.DELAY_SLOT(1'b0)) u_nds (
        .clk(clk), .reset(reset), .stall(stall), .D_PC(D_PC),
        .instr_index_offset(instr_index_offset), .register_value(register_value),
        .branch(branch), .jump(jump), .cmp_result(cmp_result), .exc_req(exc_req),
        .eret_req(eret_req), .epc(epc), .cnt_clear(cnt_clear),
        .F_PC(f_pc_b), .next_PC(next_b), .flush_fd(flush_b),
        .fetch_fault(fault_b), .redirect_count(cnt_b)
    );

    pc_gen #(.COUNT_WIDTH(2)) u_c2 (
        .clk(clk), .reset(reset), .stall(stall), .D_PC(D_PC),
        .instr_index_offset(instr_index_offset), .register_value(register_value),
        .branch(branch), .jump(jump), .cmp_result(cmp_result), .exc_req(exc_req),
        .eret_req(eret_req), .epc(epc), .cnt_clear(cnt_clear),
        .F_PC(f_pc_c), .next_PC(next_c), .flush_fd(flush_c),
        .fetch_fault(fault_c), .redirect_count(cnt_c)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: architectural rules expressed directly.
    function automatic bit m_taken();
        return (jump == 2'd1) || (jump == 2'd2) || (branch == 2'd2) ||
               ((branch == 2'd1) && cmp_result);
    endfunction

    function automatic logic [31:0] m_next();
        logic [31:0] off;
        off = {{14{instr_index_offset[15]}}, instr_index_offset[15:0], 2'b00};
        if (exc_req)  return 32'h0000_4180;
        if (eret_req) return epc;
        if (m_taken()) begin
            if (jump == 2'd1) return {D_PC[31:28], instr_index_offset, 2'b00};
            if (jump == 2'd2) return register_value;
            return D_PC + 32'd4 + off;
        end
        return m_pc + 32'd4;
    endfunction

    function automatic bit m_fault();
        return (m_pc[1:0] != 2'b00) || (m_pc < 32'h3000) || (m_pc >= 32'h6000);
    endfunction

    task automatic m_clock();
        bit inc;
        logic [31:0] nxt;
        nxt = m_next();
        inc = m_taken() && !stall && !exc_req && !eret_req;
        if (reset) begin
            m_pc = 32'h3000; m_cnt16 = 0; m_cnt2 = 0;
        end else begin
            if (exc_req || eret_req || !stall) m_pc = nxt;
            if (cnt_clear) begin
                m_cnt16 = 0; m_cnt2 = 0;
            end else if (inc) begin
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
    endtask

    // Inputs are already applied; compare outputs mid-cycle, then advance one edge.
    task automatic cycle();
        bit exp_flush;
        #2;
        if (!reset) begin
            exp_flush = exc_req || eret_req;
            check("F_PC", f_pc_a, m_pc);
            check("next_PC", next_a, m_next());
            check("fetch_fault", fault_a, m_fault());
            check("flush_ds1", flush_a, exp_flush);
            check("flush_ds0", flush_b, exp_flush || (m_taken() && !stall));
            check("count16", cnt_a, m_cnt16);
            check("count2", cnt_c, m_cnt2);
            check("F_PC_cw2", f_pc_c, m_pc);
        end
        @(posedge clk);
        m_clock();
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; stall = 0; cmp_result = 0; exc_req = 0; eret_req = 0; cnt_clear = 0;
        D_PC = 32'h3000; register_value = 32'h3000; epc = 32'h3000;
        instr_index_offset = '0; branch = 0; jump = 0;
    endtask

    task automatic rand_inputs();
        D_PC               = 32'h3000 + ($urandom_range(0, 3071) << 2);
        instr_index_offset = 26'($urandom);
        register_value     = ($urandom_range(0, 1) == 1) ? 32'h3000 + ($urandom_range(0, 3071) << 2)
                                                          : $urandom;
        epc                = 32'h3000 + ($urandom_range(0, 3071) << 2);
        branch             = 2'($urandom_range(0, 3));
        jump               = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
        cmp_result         = 1'($urandom);
        stall              = ($urandom_range(0, 3) == 0);
        exc_req            = ($urandom_range(0, 19) == 0);
        eret_req           = ($urandom_range(0, 19) == 0);
        cnt_clear          = ($urandom_range(0, 19) == 0);
        reset              = ($urandom_range(0, 39) == 0);
    endtask

    initial begin
        m_pc = 32'h3000; m_cnt16 = 0; m_cnt2 = 0;
        idle_inputs();
        @(posedge clk); #1;
        reset = 1;
        cycle();
        reset = 0;
        #1;
        check("reset_F_PC", f_pc_a, 32'h3000);
        check("reset_count", cnt_a, 0);
        check("reset_flush", flush_a, 1'b0);
        check("reset_next", next_a, 32'h3004);
        repeat (3) cycle();
        check("seq_F_PC", f_pc_a, 32'h300C);

        // Conditional branch back to 0x3004
        D_PC = 32'h3010; branch = 1; cmp_result = 1; instr_index_offset = 26'h000FFFC;
        #1;
        check("br_next", next_a, 32'h3004);
        check("br_flush_ds1", flush_a, 1'b0);
        check("br_flush_ds0", flush_b, 1'b1);
        cycle();
        check("br_F_PC", f_pc_a, 32'h3004);
        check("br_count", cnt_a, 1);
        check("br_count_ds0", cnt_b, 1);

        // Jump-register held by a two-cycle stall
        idle_inputs();
        jump = 2; register_value = 32'h3400; stall = 1;
        cycle(); cycle();
        check("stall_hold", f_pc_a, 32'h3004);
        stall = 0;
        cycle();
        check("stall_release", f_pc_a, 32'h3400);
        check("stall_count", cnt_a, 2);

        // Exception and eret together, under stall, with a jump pending
        idle_inputs();
        exc_req = 1; eret_req = 1; stall = 1; jump = 1; epc = 32'h3100;
        #1;
        check("exc_flush", flush_a, 1'b1);
        cycle();
        check("exc_F_PC", f_pc_a, 32'h4180);
        check("exc_count", cnt_a, 2);

        // Misaligned and out-of-window fetch addresses
        idle_inputs();
        jump = 2; register_value = 32'h3002;
        cycle();
        check("misalign_F_PC", f_pc_a, 32'h3002);
        check("misalign_fault", fault_a, 1'b1);
        register_value = 32'h6000;
        cycle();
        check("window_fault", fault_a, 1'b1);

        // Wrap from the top of the address space
        register_value = 32'hFFFF_FFFC;
        cycle();
        jump = 0;
        cycle();
        check("wrap_F_PC", f_pc_a, 32'h0);
        check("wrap_fault", fault_a, 1'b1);

        // Two-bit counter saturation and clear-over-increment
        idle_inputs();
        cnt_clear = 1;
        cycle();
        cnt_clear = 0; branch = 2; D_PC = 32'h3000; instr_index_offset = '0;
        repeat (5) cycle();
        check("sat_count2", cnt_c, 2'd3);
        cnt_clear = 1;
        cycle();
        check("clear_wins", cnt_c, 2'd0);

        // Randomised traffic against the model
        for (int i = 0; i < 2000; i++) begin
            rand_inputs();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
